sha256_w_stream_reader: RTL and testbench

- Consumer-side counterpart to the pipelined message-schedule window registers.
- Accepts one 512-bit padded message block over a valid/ready handshake.
- Streams W_0..W_{NUM_ROUNDS-1} to the compression-round datapath, one 32-bit word per handshake, with iterative expansion in a 16-word sliding window.
- Sits between the block/header source and the round unit in the double-SHA256 path.

---
 rtl/sha256_pkg.sv | 26 ++
 rtl/sha256_w_expand.sv | 14 +
 rtl/sha256_w_stream_reader.sv | 99 +++++++++
 tb/tb_sha256_w_stream_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and small-sigma helpers for the SHA-256 message schedule.
// Padding constants apply when the core is built with SHA256_W_DOUBLE_PAD_EN.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int NUM_ROUNDS_DEFAULT = 64;

  // Fixed padding for hashing a 256-bit digest: a single 1 bit, then length = 256.
  localparam word_t W8_PAD  = 32'h8000_0000;
  localparam word_t W15_PAD = 32'h0000_0100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  function automatic word_t s0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion: next word from the four taps of the 16-word window.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  word_t w0_i,
  input  word_t w1_i,
  input  word_t w9_i,
  input  word_t w14_i,
  output word_t w_next_o
);

  assign w_next_o = s1(w14_i) + w9_i + s0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_w_stream_reader.sv
// Accepts one 512-bit block and streams W_0..W_{NUM_ROUNDS-1} over a valid/ready port.
// Optional build macro SHA256_W_DOUBLE_PAD_EN adds second_hash digest padding.
module sha256_w_stream_reader
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [511:0] block_in,
  input  logic         block_valid,
  output logic         block_ready,
`ifdef SHA256_W_DOUBLE_PAD_EN
  input  logic         second_hash,
`endif
  output logic [31:0]  w_out,
  output logic [5:0]   t_out,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         done,
  output state_e       state_dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and data is held unchanged while valid & !ready.

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  state_e      state_q;
  word_t       wnd_q [16];
  logic [5:0]  t_q;
  logic        w_valid_q;
  logic        done_q;
  word_t       load_d [16];
  word_t       w_next_d;

  always_comb begin
    for (int i = 0; i < 16; i++) load_d[i] = block_in[511 - 32*i -: 32];
`ifdef SHA256_W_DOUBLE_PAD_EN
    if (second_hash) begin
      load_d[8] = W8_PAD;
      for (int i = 9; i < 15; i++) load_d[i] = '0;
      load_d[15] = W15_PAD;
    end
`endif
  end

  sha256_w_expand u_expand (
    .w0_i     (wnd_q[0]),
    .w1_i     (wnd_q[1]),
    .w9_i     (wnd_q[9]),
    .w14_i    (wnd_q[14]),
    .w_next_o (w_next_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 16; i++) wnd_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (block_valid) begin
            for (int i = 0; i < 16; i++) wnd_q[i] <= load_d[i];
            t_q       <= '0;
            w_valid_q <= 1'b1;
            state_q   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // w_valid is always 1 here, so w_ready alone marks a transfer.
          if (w_ready) begin
            if (t_q == LAST_T) begin
              w_valid_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              for (int i = 0; i < 15; i++) wnd_q[i] <= wnd_q[i+1];
              wnd_q[15] <= w_next_d;
              t_q       <= t_q + 6'd1;
            end
          end
        end
      endcase
    end
  end

  assign block_ready = (state_q == ST_IDLE);
  assign w_out       = wnd_q[0];
  assign t_out       = t_q;
  assign w_valid     = w_valid_q;
  assign done        = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sha256_w_stream_reader.sv
// Directed/randomized bench for sha256_w_stream_reader against a plain SHA-256 schedule model.
// Exercises the SHA256_W_DOUBLE_PAD_EN path when that macro is defined.
module tb_sha256_w_stream_reader;

`ifdef SHA256_W_DOUBLE_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic         CLK;
  logic         RST;
  logic [511:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [31:0]  w_out;
  logic [5:0]   t_out;
  logic         w_valid;
  logic         w_ready;
  logic         done;
  sha256_pkg::state_e state_dbg;
`ifdef SHA256_W_DOUBLE_PAD_EN
  logic         second_hash;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [37:0] exp_q[$];
  logic [31:0] obs_w [64];

  sha256_w_stream_reader dut (
    .CLK         (CLK),
    .RST         (RST),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
`ifdef SHA256_W_DOUBLE_PAD_EN
    .second_hash (second_hash),
`endif
    .w_out       (w_out),
    .t_out       (t_out),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .done        (done),
    .state_dbg_o (state_dbg)
  );

  // Clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: textbook schedule recurrence over a full 64-entry array.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic compute_ref(input logic [511:0] blk, input bit sh);
    logic [31:0] w [64];
    logic [31:0] sg0, sg1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    if (sh && PAD_EN) begin
      w[8] = 32'h8000_0000;
      for (int i = 9; i < 15; i++) w[i] = 32'h0;
      w[15] = 32'h0000_0100;
    end
    for (int i = 16; i < 64; i++) begin
      sg0  = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      sg1  = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = sg1 + w[i-7] + sg0 + w[i-16];
    end
    for (int i = 0; i < 64; i++) exp_q.push_back({i[5:0], w[i]});
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  // Driver: present a block (called at a negedge), wait for acceptance, check W_0 latency.
  task automatic send_block(input logic [511:0] blk, input bit sh);
    int cyc = 0;
    compute_ref(blk, sh);
    block_in    = blk;
    block_valid = 1'b1;
`ifdef SHA256_W_DOUBLE_PAD_EN
    second_hash = sh;
`endif
    while (!block_ready && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    check("accept_ready", block_ready, 1'b1);
    @(negedge CLK);
    block_valid = 1'b0;
    check("w0_latency", w_valid, 1'b1);
  endtask

  // Consumer + scoreboard: pops exp_q on each handshake, checks holds during stalls.
  task automatic consume(input int pct, input int max_hs);
    int hs = 0;
    int cyc = 0;
    int early_done = 0;
    int target;
    bit stalled = 1'b0;
    logic [31:0] held_w;
    logic [5:0]  held_t;
    logic [37:0] e;
    target = (max_hs < exp_q.size()) ? max_hs : exp_q.size();
    while (hs < target && cyc < 2000) begin
      if (done) early_done++;
      if (stalled) check("stall_hold", {w_valid, t_out, w_out}, {1'b1, held_t, held_w});
      w_ready = ($urandom_range(99) < pct);
      if (w_valid && w_ready) begin
        e = exp_q.pop_front();
        check("word", {t_out, w_out}, e);
        obs_w[t_out] = w_out;
        hs++;
      end
      stalled = w_valid && !w_ready;
      held_w  = w_out;
      held_t  = t_out;
      @(negedge CLK);
      cyc++;
    end
    w_ready = 1'b0;
    check("handshakes", hs, target);
    check("no_early_done", early_done, 0);
    if (hs < target) exp_q.delete();
  endtask

  task automatic end_done();
    check("done_pulse", done, 1'b1);
    check("done_w_valid", w_valid, 1'b0);
    check("done_ready", block_ready, 1'b1);
    @(negedge CLK);
    check("done_single", done, 1'b0);
  endtask

  localparam logic [511:0] ABC = {32'h6162_6380, 448'h0, 32'h0000_0018};

  initial begin
    logic [511:0] blk_a, blk_b;
    RST         = 1'b1;
    block_in    = '0;
    block_valid = 1'b0;
    w_ready     = 1'b0;
`ifdef SHA256_W_DOUBLE_PAD_EN
    second_hash = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("rst_ready", block_ready, 1'b1);
    check("rst_w_valid", w_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_w_out", w_out, 32'h0);
    check("rst_t_out", t_out, 6'd0);
    RST = 1'b0;
    @(negedge CLK);

    // "abc" block, ready held high
    send_block(ABC, 1'b0);
    consume(100, 64);
    check("abc_w16", obs_w[16], 32'h6162_6380);
    check("abc_w17", obs_w[17], 32'h000F_0000);
    check("abc_w18", obs_w[18], 32'h7DA8_6405);
    check("abc_w63", obs_w[63], 32'h12B1_EDEB);
    end_done();

    // Same block with random 50% back-pressure
    send_block(ABC, 1'b0);
    consume(50, 64);
    check("abc_stall_w63", obs_w[63], 32'h12B1_EDEB);
    end_done();

    // Back-to-back blocks, block_valid held high, data changed during STREAM
    blk_a = rand_block();
    blk_b = rand_block();
    compute_ref(blk_a, 1'b0);
    block_in    = blk_a;
    block_valid = 1'b1;
    check("b2b_ready", block_ready, 1'b1);
    @(negedge CLK);
    block_in = blk_b;
    check("busy_ready", block_ready, 1'b0);
    consume(100, 64);
    check("b2b_done", done, 1'b1);
    check("b2b_done_ready", block_ready, 1'b1);
    compute_ref(blk_b, 1'b0);
    @(negedge CLK);
    block_valid = 1'b0;
    check("b2b_no_gap", w_valid, 1'b1);
    check("b2b_done_clear", done, 1'b0);
    consume(100, 64);
    end_done();

    // Reset in the middle of a block
    send_block(rand_block(), 1'b0);
    consume(100, 20);
    check("pre_rst_t", t_out, 6'd20);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    check("mid_rst_w_valid", w_valid, 1'b0);
    check("mid_rst_ready", block_ready, 1'b1);
    check("mid_rst_t", t_out, 6'd0);
    check("mid_rst_done", done, 1'b0);
    @(negedge CLK);
    check("mid_rst_no_done", done, 1'b0);
    send_block(rand_block(), 1'b0);
    consume(50, 64);
    end_done();

`ifdef SHA256_W_DOUBLE_PAD_EN
    // Second-hash padding: lower half of block_in must be ignored
    blk_a = rand_block();
    send_block({blk_a[511:256], {256{1'b1}}}, 1'b1);
    consume(70, 64);
    check("pad_w8", obs_w[8], 32'h8000_0000);
    check("pad_w9", obs_w[9], 32'h0);
    check("pad_w14", obs_w[14], 32'h0);
    check("pad_w15", obs_w[15], 32'h0000_0100);
    end_done();
    second_hash = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
